multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RST.
REQ-002 Parameter WIDTH, default 16: operand/result width in bits.
REQ-003 Parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1; N = WIDTH/CHUNK.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 START  in  1  request; sampled on CLK rising edge.
REQ-007 MODE  in  1  0 = add, 1 = subtract; sampled with START.
REQ-008 X  in  WIDTH  operand A; sampled with START.
REQ-009 Y  in  WIDTH  operand B; sampled with START.
REQ-010 CARRY_IN  in  1  carry into bit 0, add mode only; sampled with START.
REQ-011 BUSY  out  1  high while an operation is in progress.
REQ-012 DONE  out  1  one-cycle pulse: result valid.
REQ-013 SUM  out  WIDTH  result, registered, held until the next DONE.
REQ-014 CARRY_OUT  out  1  carry out of bit WIDTH-1, registered.
REQ-015 OVERFLOW  out  1  two's-complement signed overflow, registered.

Function
REQ-016 FSM states SHALL be IDLE and RUN, plus a chunk counter 0..N-1.
REQ-017 IDLE: START=1 at an edge SHALL latch operands and go to RUN with counter 0.
  - Latched values: X; Y (add) or ~Y (subtract); carry = CARRY_IN (add) or 1 (subtract).
REQ-018 Subtract SHALL compute X - Y, with CARRY_IN ignored; CARRY_OUT=1 means no borrow.
REQ-019 RUN, each edge: add chunk [counter*CHUNK +: CHUNK] of both operands plus the carry register (ripple-carry, CHUNK bits); store the chunk sum and the new carry; increment counter.
REQ-020 RUN, edge with counter = N-1: go to IDLE; update SUM, CARRY_OUT, OVERFLOW; assert DONE for exactly the following cycle.
  - OVERFLOW = carry into MSB XOR carry out of MSB.
REQ-021 Latency SHALL be N+1 cycles: START sampled at edge t0, DONE high during the cycle after edge t0+N.
REQ-022 BUSY SHALL be high exactly during RUN (cycles after edges t0 .. t0+N-1); it SHALL be low in the DONE cycle.
REQ-023 START while BUSY=1 SHALL be ignored: no effect on the operation in progress or its result.
REQ-024 START=1 in the DONE cycle SHALL be accepted (back-to-back); the issue interval SHALL be N+1 cycles.
REQ-025 Input changes on X/Y/MODE/CARRY_IN after the START edge SHALL NOT affect the result.
REQ-026 SUM/CARRY_OUT/OVERFLOW SHALL change only at the DONE edge; partial results SHALL NOT be visible on SUM.
REQ-027 CHUNK = WIDTH SHALL give N = 1: BUSY high for one cycle, DONE two cycles after the START edge.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; the full carry chain SHALL cross chunk boundaries through the carry register.

Reset
REQ-029 RST=1 SHALL immediately, without waiting for a clock edge, force: state IDLE, counter 0, BUSY=0, DONE=0, SUM=0, CARRY_OUT=0, OVERFLOW=0.
REQ-030 RST asserted mid-operation SHALL abort the operation: no DONE is issued for it, and the first START after RST deasserts SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 Add 0x1234 + 0x0FFF, CARRY_IN=0 -> SUM=0x2233, CARRY_OUT=0, OVERFLOW=0; DONE exactly 5 cycles after START; BUSY high 4 cycles.
REQ-032 Add 0xFFFF + 0x0001, CARRY_IN=0 -> SUM=0x0000, CARRY_OUT=1, OVERFLOW=0; add 0x7FFF + 0x0000, CARRY_IN=1 -> SUM=0x8000, OVERFLOW=1.
REQ-033 Subtract 0x0005 - 0x0007, CARRY_IN=1 (ignored) -> SUM=0xFFFE, CARRY_OUT=0; subtract 0x8000 - 0x0001 -> SUM=0x7FFF, OVERFLOW=1.
REQ-034 START with 0x0004 + 0x0008; second START with 0x0003 + 0x0007 while BUSY -> one DONE only, SUM=0x000C; then a START in the DONE cycle with 0x000C + 0x0005 -> SUM=0x0011 after N+1 cycles.
REQ-035 RST pulsed two cycles after START -> all outputs 0 asynchronously, no DONE; following START 0x0001 + 0x0001 -> SUM=0x0002.
REQ-036 WIDTH=4, CHUNK=4, exhaustive 256 operand pairs x both CARRY_IN values -> {CARRY_OUT,SUM} = X+Y+CARRY_IN; DONE two cycles after each START.

Source files
------------

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - chunk-serial ripple adder/subtractor, CHUNK bits per cycle
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CARRY_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY_OUT,
    output logic             OVERFLOW
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;

    logic             accept;
    logic             last;
    int unsigned      chunk_base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_full;
    logic             msb_cin;
    logic [WIDTH-1:0] result;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: leave IDLE on START, return after the last chunk
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (cnt == LAST);
        case (state)
            IDLE: if (START) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign BUSY = (state == RUN);

    // One chunk of ripple-carry addition; result merges it with earlier chunks
    always_comb begin
        chunk_base = int'(cnt) * CHUNK;
        a_chunk    = op_a[chunk_base +: CHUNK];
        b_chunk    = op_b[chunk_base +: CHUNK];
        chunk_full = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        // carry into the chunk's top bit recovered from its sum bit
        msb_cin    = chunk_full[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        result     = acc;
        result[chunk_base +: CHUNK] = chunk_full[CHUNK-1:0];
    end

    // Operand latch, chunk stepping and result publication at the final chunk
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            DONE      <= 1'b0;
            SUM       <= '0;
            CARRY_OUT <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                cnt   <= '0;
                op_a  <= X;
                op_b  <= MODE ? ~Y : Y;
                carry <= MODE ? 1'b1 : CARRY_IN;
                acc   <= '0;
            end else if (state == RUN) begin
                acc   <= result;
                carry <= chunk_full[CHUNK];
                if (last) begin
                    cnt       <= '0;
                    DONE      <= 1'b1;
                    SUM       <= result;
                    CARRY_OUT <= chunk_full[CHUNK];
                    OVERFLOW  <= msb_cin ^ chunk_full[CHUNK];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - self-checking bench for multicycle_adder
module tb_multicycle_adder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    logic        s_start = 1'b0;
    logic [3:0]  s_x = '0;
    logic [3:0]  s_y = '0;
    logic        s_cin = 1'b0;
    logic        s_busy, s_done, s_cout, s_ovf;
    logic [3:0]  s_sum;

    int total = 0;
    int bad   = 0;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .MODE(mode), .X(x), .Y(y),
        .CARRY_IN(cin), .BUSY(busy), .DONE(done), .SUM(sum),
        .CARRY_OUT(cout), .OVERFLOW(ovf)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .CLK(clk), .RST(rst), .START(s_start), .MODE(1'b0), .X(s_x), .Y(s_y),
        .CARRY_IN(s_cin), .BUSY(s_busy), .DONE(s_done), .SUM(s_sum),
        .CARRY_OUT(s_cout), .OVERFLOW(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {overflow, carry_out, sum} from plain arithmetic
    function automatic logic [17:0] model_op(input logic m, input logic [15:0] a,
                                             input logic [15:0] b, input logic c);
        logic [15:0] bb;
        logic [16:0] f;
        logic        o;
        bb = m ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + 17'(m ? 1'b1 : c);
        o  = (a[15] == bb[15]) && (f[15] != a[15]);
        return {o, f};
    endfunction

    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [17:0] m_res = '0;
    logic [17:0] p_res = '0;

    // Transaction-level model: remaining cycles of the accepted operation
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) m_res <= p_res;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                p_res <= model_op(mode, x, y, cin);
                m_cnt <= N;
            end
        end
    end

    // Compare the wide DUT with the model every cycle
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("sum", {16'd0, sum}, {16'd0, m_res[15:0]});
        chk("carry_out", {31'd0, cout}, {31'd0, m_res[16]});
        chk("overflow", {31'd0, ovf}, {31'd0, m_res[17]});
    end

    // Issue one operation at a negedge and wait for DONE; optionally fire a stray START while busy
    task automatic run_op(input logic m, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] e_sum, input logic e_co,
                          input logic e_ov, input bit inject);
        int k = 0;
        int busy_n = 0;
        bit got = 0;
        start = 1'b1; mode = m; x = a; y = b; cin = c;
        while (k < 20 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                x = 16'($urandom); y = 16'($urandom);
                mode = 1'($urandom); cin = 1'($urandom);
            end
            if (inject && k == 2) begin
                start = 1'b1; mode = 1'b0; x = 16'h0003; y = 16'h0007; cin = 1'b0;
            end
            if (inject && k == 3) start = 1'b0;
            if (busy) busy_n++;
            if (done) got = 1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", k, N + 1);
        chk("busy_cycles", busy_n, N);
        chk("lit_sum", {16'd0, sum}, {16'd0, e_sum});
        chk("lit_carry_out", {31'd0, cout}, {31'd0, e_co});
        chk("lit_overflow", {31'd0, ovf}, {31'd0, e_ov});
    endtask

    initial begin
        logic [4:0] e4;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0);
        run_op(1'b0, 16'h0004, 16'h0008, 1'b0, 16'h000C, 1'b0, 1'b0, 1);
        run_op(1'b0, 16'h000C, 16'h0005, 1'b0, 16'h0011, 1'b0, 1'b0, 0);

        // Abort an operation with reset two cycles in
        start = 1'b1; mode = 1'b0; x = 16'h1111; y = 16'h2222; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_sum", {16'd0, sum}, 32'd0);
        chk("async_carry_out", {31'd0, cout}, 32'd0);
        chk("async_overflow", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Exhaustive single-chunk configuration
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    s_start = 1'b1; s_x = 4'(xi); s_y = 4'(yi); s_cin = 1'(ci);
                    e4 = 5'(xi + yi + ci);
                    @(negedge clk);
                    s_start = 1'b0; s_x = 4'($urandom); s_y = 4'($urandom);
                    s_cin = 1'($urandom);
                    chk("n1_busy", {31'd0, s_busy}, 32'd1);
                    chk("n1_early_done", {31'd0, s_done}, 32'd0);
                    @(negedge clk);
                    chk("n1_done", {31'd0, s_done}, 32'd1);
                    chk("n1_result", {27'd0, s_cout, s_sum}, {27'd0, e4});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
